// File: rtl/dsp_trace_pkg.sv
// Shared types and default widths for the DSP writeback trace buffer.
package dsp_trace_pkg;

    // Default widths, matching the DSP core's instruction/data word and register file.
    localparam int DSP_DATA_W  = 36;
    localparam int DSP_ADDR_W  = 10;
    localparam int DSP_PC_W    = 10;
    localparam int DSP_STAMP_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } trace_state_t;

    // One trace record at default widths, MSB first as presented on rd_data.
    typedef struct packed {
        logic [DSP_STAMP_W-1:0] stamp;
        logic [DSP_PC_W-1:0]    pc;
        logic [DSP_ADDR_W-1:0]  addr;
        logic [DSP_DATA_W-1:0]  data;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
module trace_fifo #(
    parameter  int W     = 66,
    parameter  int DEPTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [W-1:0]     r_head;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [W-1:0]     w_head_next;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_head;

    // A push into a full FIFO only lands when the head leaves in the same cycle.
    assign w_pop      = pop && !empty && !clear;
    assign w_push     = push && !clear && (!full || w_pop);
    assign w_rd_next  = r_rd_ptr + PTR_W'(w_pop);
    assign w_cnt_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

    // Next head: bypass the incoming word when it lands in the head slot.
    always_comb begin
        w_head_next = r_head;
        if (w_cnt_next != '0) begin
            if (w_push && (r_wr_ptr == w_rd_next))
                w_head_next = din;
            else
                w_head_next = r_mem[w_rd_next];
        end
    end

    // Storage array, no reset needed since only valid slots are ever read out.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= din;
    end

    // Pointers, occupancy and the registered head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push);
            r_rd_ptr <= w_rd_next;
            r_count  <= w_cnt_next;
            r_head   <= w_head_next;
        end
    end

endmodule

// File: rtl/dsp_trace_capture.sv
// Writeback trace capture: framing FSM, per-sample stamp, address filter and FIFO.
module dsp_trace_capture
    import dsp_trace_pkg::*;
#(
    parameter  int DATA_W  = DSP_DATA_W,
    parameter  int ADDR_W  = DSP_ADDR_W,
    parameter  int PC_W    = DSP_PC_W,
    parameter  int STAMP_W = DSP_STAMP_W,
    parameter  int DEPTH   = 64,
    localparam int REC_W   = STAMP_W + PC_W + ADDR_W + DATA_W,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] addr_w,
    input  logic [DATA_W-1:0] data_w,
    input  logic [PC_W-1:0]   pc_wb,
    input  logic              arm,
    input  logic              disarm,
    input  logic              cont,
    input  logic              filt_en,
    input  logic [ADDR_W-1:0] filt_lo,
    input  logic [ADDR_W-1:0] filt_hi,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [REC_W-1:0]  rd_data,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    trace_state_t       r_state;
    logic               r_cont;
    logic               r_filt_en;
    logic [ADDR_W-1:0]  r_filt_lo;
    logic [ADDR_W-1:0]  r_filt_hi;
    logic [STAMP_W-1:0] r_stamp;
    logic               r_overflow;

    logic               w_clear;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_in_win;
    logic               w_push_req;
    logic               w_push_acc;
    logic               w_will_full;
    logic [CNT_W-1:0]   w_count;

    // disarm beats arm, so a simultaneous pair leaves the buffer intact.
    assign w_clear  = arm && !disarm;
    assign w_pop    = !w_empty && rd_ready;
    // An inverted window (lo > hi) naturally matches nothing.
    assign w_in_win = !r_filt_en || ((addr_w >= r_filt_lo) && (addr_w <= r_filt_hi));
    // The start that ends a single-shot frame does not capture its coincident write.
    assign w_push_req = write_en && (r_state == ST_CAPTURE) && w_in_win && !(start && !r_cont);
    assign w_push_acc = w_push_req && (!w_full || w_pop);
    // Occupancy after this edge reaches DEPTH: single-shot must be DONE before the next write.
    assign w_will_full = (w_full && (w_push_acc || !w_pop)) ||
                         ((w_count == CNT_W'(DEPTH - 1)) && w_push_acc && !w_pop);

    trace_fifo #(
        .W     (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (w_push_acc),
        .pop     (w_pop),
        .clear   (w_clear),
        .din     ({r_stamp, pc_wb, addr_w, data_w}),
        .dout    (rd_data),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign rd_valid = !w_empty;
    assign state    = r_state;
    assign count    = w_count;
    assign overflow = r_overflow;

    // Cycle stamp: zero in the cycle after start, saturating at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_stamp <= '0;
        else if (start)
            r_stamp <= '0;
        else if (r_stamp != '1)
            r_stamp <= r_stamp + STAMP_W'(1);
    end

    // Capture configuration latched on arm; sticky overflow on a dropped qualifying write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cont     <= 1'b0;
            r_filt_en  <= 1'b0;
            r_filt_lo  <= '0;
            r_filt_hi  <= '0;
            r_overflow <= 1'b0;
        end else if (w_clear) begin
            r_cont     <= cont;
            r_filt_en  <= filt_en;
            r_filt_lo  <= filt_lo;
            r_filt_hi  <= filt_hi;
            r_overflow <= 1'b0;
        end else if (w_push_req && !w_push_acc) begin
            r_overflow <= 1'b1;
        end
    end

    // Framing FSM: disarm, then arm, then the per-state triggers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= ST_IDLE;
        else if (disarm)
            r_state <= ST_IDLE;
        else if (arm)
            r_state <= ST_ARMED;
        else begin
            case (r_state)
                ST_ARMED:   if (start) r_state <= ST_CAPTURE;
                ST_CAPTURE: if (!r_cont && (start || w_will_full)) r_state <= ST_DONE;
                default:    ;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_trace_capture.sv
// Bench for dsp_trace_capture: table vectors, directed corner sequences, random vs. model.
module tb_dsp_trace_capture;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        write_en;
    logic [9:0]  addr_w;
    logic [35:0] data_w;
    logic [9:0]  pc_wb;
    logic        arm;
    logic        disarm;
    logic        cont;
    logic        filt_en;
    logic [9:0]  filt_lo;
    logic [9:0]  filt_hi;
    logic        rd_valid;
    logic        rd_ready;
    logic [65:0] rd_data;
    logic [1:0]  state;
    logic [2:0]  count;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    dsp_trace_capture #(.DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .write_en (write_en),
        .addr_w   (addr_w),
        .data_w   (data_w),
        .pc_wb    (pc_wb),
        .arm      (arm),
        .disarm   (disarm),
        .cont     (cont),
        .filt_en  (filt_en),
        .filt_lo  (filt_lo),
        .filt_hi  (filt_hi),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .state    (state),
        .count    (count),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model: a queue of records plus frame state ----------------
    logic [65:0] mq[$];
    int          m_state;
    int          m_stamp;
    bit          m_ovf, m_cont, m_filt;
    int          m_lo, m_hi;

    function automatic logic [65:0] rec(int s, logic [9:0] pc, logic [9:0] a, logic [35:0] d);
        return {10'(s), pc, a, d};
    endfunction

    function automatic logic [65:0] exp_rec(int s, logic [9:0] a, logic [35:0] d);
        return rec(s, d[9:0] ^ 10'h2AA, a, d);
    endfunction

    task automatic model_reset();
        mq.delete();
        m_state = 0; m_stamp = 0; m_ovf = 0; m_cont = 0; m_filt = 0; m_lo = 0; m_hi = 0;
    endtask

    task automatic model_step();
        bit pop, qual, inwin;
        pop   = (mq.size() != 0) && rd_ready;
        inwin = !m_filt || ((int'(addr_w) >= m_lo) && (int'(addr_w) <= m_hi));
        qual  = write_en && (m_state == 2) && inwin && !(start && !m_cont);
        if (arm && !disarm) begin
            mq.delete();
            m_ovf = 0; m_cont = cont; m_filt = filt_en;
            m_lo = int'(filt_lo); m_hi = int'(filt_hi);
            m_state = 1;
        end else begin
            if (pop) void'(mq.pop_front());
            if (qual) begin
                if (mq.size() < DEPTH) mq.push_back(rec(m_stamp, pc_wb, addr_w, data_w));
                else m_ovf = 1;
            end
            if (disarm) m_state = 0;
            else if (m_state == 1 && start) m_state = 2;
            else if (m_state == 2 && !m_cont && (start || mq.size() == DEPTH)) m_state = 3;
        end
        m_stamp = start ? 0 : ((m_stamp == 1023) ? 1023 : m_stamp + 1);
    endtask

    // ---------------- helpers ----------------
    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chkd(input string nm, input logic [65:0] act, input logic [65:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic a, input logic s, input logic w, input logic [9:0] ad,
                       input logic [35:0] d, input logic r, input logic dis);
        arm = a; start = s; write_en = w; addr_w = ad; data_w = d; rd_ready = r; disarm = dis;
        pc_wb = d[9:0] ^ 10'h2AA;
        tick();
        arm = 1'b0; start = 1'b0; write_en = 1'b0; rd_ready = 1'b0; disarm = 1'b0;
    endtask

    task automatic idle(); cyc(0, 0, 0, 10'h0, 36'h0, 0, 0); endtask

    task automatic do_reset();
        arm = 0; disarm = 0; start = 0; write_en = 0; rd_ready = 0;
        addr_w = '0; data_w = '0; pc_wb = '0;
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // ---------------- table vectors: single-shot unfiltered frame ----------------
    typedef struct {
        logic        a, s, w, r;
        logic [35:0] d;
        logic [9:0]  pc;
        int          e_state;
        int          e_count;
        logic        ck;
        logic [65:0] e_data;
    } vec_t;

    vec_t tbl[12];

    function automatic vec_t mk(logic a, logic s, logic w, logic r, logic [35:0] d, logic [9:0] pc,
                                int es, int ec, logic ck, logic [65:0] ed);
        vec_t v;
        v.a = a; v.s = s; v.w = w; v.r = r; v.d = d; v.pc = pc;
        v.e_state = es; v.e_count = ec; v.ck = ck; v.e_data = ed;
        return v;
    endfunction

    initial begin
        logic [65:0] r2, r3, r4, hold;
        reset_n = 1'b0; start = 0; write_en = 0; addr_w = '0; data_w = '0; pc_wb = '0;
        arm = 0; disarm = 0; cont = 0; filt_en = 0; filt_lo = '0; filt_hi = '0; rd_ready = 0;

        r2 = rec(2, 10'h010, 10'h001, 36'h400);
        r3 = rec(3, 10'h011, 10'h001, 36'h800);
        r4 = rec(4, 10'h012, 10'h001, 36'hC00);
        tbl[0]  = mk(1, 0, 0, 0, 36'h0,   10'h0,   1, 0, 0, '0);
        tbl[1]  = mk(0, 1, 0, 0, 36'h0,   10'h0,   2, 0, 0, '0);
        tbl[2]  = mk(0, 0, 0, 0, 36'h0,   10'h0,   2, 0, 0, '0);
        tbl[3]  = mk(0, 0, 0, 0, 36'h0,   10'h0,   2, 0, 0, '0);
        tbl[4]  = mk(0, 0, 1, 0, 36'h400, 10'h010, 2, 1, 1, r2);
        tbl[5]  = mk(0, 0, 1, 0, 36'h800, 10'h011, 2, 2, 1, r2);
        tbl[6]  = mk(0, 0, 1, 0, 36'hC00, 10'h012, 2, 3, 1, r2);
        tbl[7]  = mk(0, 1, 0, 0, 36'h0,   10'h0,   3, 3, 1, r2);
        tbl[8]  = mk(0, 0, 1, 0, 36'hFFF, 10'h013, 3, 3, 1, r2);
        tbl[9]  = mk(0, 0, 0, 1, 36'h0,   10'h0,   3, 2, 1, r3);
        tbl[10] = mk(0, 0, 0, 1, 36'h0,   10'h0,   3, 1, 1, r4);
        tbl[11] = mk(0, 0, 0, 1, 36'h0,   10'h0,   3, 0, 0, '0);

        do_reset();
        chki("reset state", int'(state), 0);
        chki("reset count", int'(count), 0);
        chki("reset overflow", int'(overflow), 0);
        chki("reset rd_valid", int'(rd_valid), 0);
        chkd("reset rd_data", rd_data, '0);

        cont = 0; filt_en = 0;
        for (int i = 0; i < 12; i++) begin
            arm = tbl[i].a; start = tbl[i].s; write_en = tbl[i].w; rd_ready = tbl[i].r;
            addr_w = 10'h001; data_w = tbl[i].d; pc_wb = tbl[i].pc; disarm = 0;
            tick();
            chki($sformatf("tbl%0d state", i), int'(state), tbl[i].e_state);
            chki($sformatf("tbl%0d count", i), int'(count), tbl[i].e_count);
            chki($sformatf("tbl%0d rd_valid", i), int'(rd_valid), int'(tbl[i].e_count != 0));
            if (tbl[i].ck) chkd($sformatf("tbl%0d rd_data", i), rd_data, tbl[i].e_data);
        end

        // ARMED-coincident write ignored; single-shot fills to DEPTH and goes DONE
        do_reset();
        cont = 0; filt_en = 0;
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 1, 1, 10'h005, 36'h1, 0, 0);
        chki("armed start write state", int'(state), 2);
        chki("armed start write count", int'(count), 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 10'h005, 36'(i + 2), 0, 0);
        chki("ss full state", int'(state), 3);
        chki("ss full count", int'(count), 4);
        cyc(0, 0, 1, 10'h005, 36'h77, 0, 0);
        chki("ss after full count", int'(count), 4);
        chki("ss after full overflow", int'(overflow), 0);

        // address window filter, then inverted window
        do_reset();
        cont = 1; filt_en = 1; filt_lo = 10'h010; filt_hi = 10'h01F;
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 1, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 0, 1, 10'h00F, 36'h1, 0, 0);
        cyc(0, 0, 1, 10'h010, 36'h2, 0, 0);
        cyc(0, 0, 1, 10'h01F, 36'h3, 0, 0);
        cyc(0, 0, 1, 10'h020, 36'h4, 0, 0);
        chki("filt count", int'(count), 2);
        chkd("filt head", rd_data, exp_rec(1, 10'h010, 36'h2));
        filt_lo = 10'h020; filt_hi = 10'h010;
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 1, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 0, 1, 10'h010, 36'h5, 0, 0);
        cyc(0, 0, 1, 10'h015, 36'h6, 0, 0);
        cyc(0, 0, 1, 10'h020, 36'h7, 0, 0);
        chki("inverted window count", int'(count), 0);

        // continuous overflow, then full + push + pop
        do_reset();
        cont = 1; filt_en = 0;
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 1, 0, 10'h0, 36'h0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 1, 10'h002, 36'h100 + 36'(i), 0, 0);
        chki("cont ovf count", int'(count), 4);
        chki("cont ovf flag", int'(overflow), 1);
        chkd("cont ovf head", rd_data, exp_rec(0, 10'h002, 36'h100));
        chki("cont ovf state", int'(state), 2);
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 0);
        chki("rearm clears overflow", int'(overflow), 0);
        chki("rearm clears count", int'(count), 0);
        cyc(0, 1, 0, 10'h0, 36'h0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 10'h002, 36'h200 + 36'(i), 0, 0);
        cyc(0, 0, 1, 10'h002, 36'h204, 1, 0);
        chki("full push pop count", int'(count), 4);
        chki("full push pop overflow", int'(overflow), 0);
        chkd("full push pop head", rd_data, exp_rec(1, 10'h002, 36'h201));

        // stamp reset across continuous frames, then backpressure
        do_reset();
        cont = 1; filt_en = 0;
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 1, 0, 10'h0, 36'h0, 0, 0);
        repeat (4) idle();
        cyc(0, 0, 1, 10'h003, 36'h11, 0, 0);
        cyc(0, 1, 1, 10'h003, 36'h22, 0, 0);
        cyc(0, 0, 1, 10'h003, 36'h33, 0, 0);
        chki("frames count", int'(count), 3);
        hold = exp_rec(4, 10'h003, 36'h11);
        for (int i = 0; i < 3; i++) begin
            idle();
            chkd($sformatf("backpressure hold %0d", i), rd_data, hold);
            chki($sformatf("backpressure valid %0d", i), int'(rd_valid), 1);
        end
        cyc(0, 0, 0, 10'h0, 36'h0, 1, 0);
        chki("single pop count", int'(count), 2);
        chkd("coincident stamp", rd_data, exp_rec(5, 10'h003, 36'h22));
        idle();
        chki("no extra pop count", int'(count), 2);
        cyc(0, 0, 0, 10'h0, 36'h0, 1, 0);
        chkd("new frame stamp", rd_data, exp_rec(0, 10'h003, 36'h33));

        // stamp saturation
        do_reset();
        cont = 1;
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 1, 0, 10'h0, 36'h0, 0, 0);
        repeat (1030) idle();
        cyc(0, 0, 1, 10'h004, 36'h5A, 0, 0);
        chkd("stamp saturates", rd_data, exp_rec(1023, 10'h004, 36'h5A));

        // disarm, arm+disarm, async reset mid-capture
        do_reset();
        cont = 0;
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 1, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 0, 1, 10'h006, 36'hA1, 0, 0);
        cyc(0, 0, 1, 10'h006, 36'hA2, 0, 0);
        cyc(0, 0, 0, 10'h0, 36'h0, 0, 1);
        chki("disarm state", int'(state), 0);
        chki("disarm count", int'(count), 2);
        chkd("disarm head", rd_data, exp_rec(0, 10'h006, 36'hA1));
        cyc(0, 0, 0, 10'h0, 36'h0, 1, 0);
        chkd("idle readout", rd_data, exp_rec(1, 10'h006, 36'hA2));
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 1);
        chki("arm+disarm state", int'(state), 0);
        chki("arm+disarm count", int'(count), 1);
        cyc(1, 0, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 1, 0, 10'h0, 36'h0, 0, 0);
        cyc(0, 0, 1, 10'h006, 36'hB1, 0, 0);
        chki("pre-reset state", int'(state), 2);
        #2 reset_n = 1'b0;
        #1;
        chki("async reset state", int'(state), 0);
        chki("async reset count", int'(count), 0);
        chki("async reset rd_valid", int'(rd_valid), 0);
        chkd("async reset rd_data", rd_data, '0);
        model_reset();
        @(posedge clk);
        #1 reset_n = 1'b1;

        // randomized traffic against the queue model
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            arm      = ($urandom_range(15) == 0);
            disarm   = ($urandom_range(59) == 0);
            start    = ($urandom_range(9) == 0);
            write_en = ($urandom_range(1) == 1);
            addr_w   = 10'($urandom_range(63));
            data_w   = 36'({$urandom(), $urandom()});
            pc_wb    = 10'($urandom());
            rd_ready = ($urandom_range(3) == 0);
            cont     = ($urandom_range(1) == 1);
            filt_en  = ($urandom_range(1) == 1);
            filt_lo  = 10'($urandom_range(63));
            filt_hi  = 10'($urandom_range(63));
            tick();
            chki("rand state", int'(state), m_state);
            chki("rand count", int'(count), mq.size());
            chki("rand overflow", int'(overflow), int'(m_ovf));
            chki("rand rd_valid", int'(rd_valid), int'(mq.size() != 0));
            if (mq.size() != 0) chkd("rand rd_data", rd_data, mq[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dsp_trace_capture.md
# dsp_trace_capture

Parametrised writeback trace buffer for the DSP core. It snoops the core's writeback port (`write_en`, `addr_w`, `data_w`, `pc_wb`) and timestamps each register write relative to the most recent `start` sample strobe. Records go into an on-chip FIFO, which a host drains over a valid/ready port. It provides hardware capture of the per-sample instruction trace, with single-shot or continuous framing and an optional address-window filter.

## Interface
- `DATA_W`, 36, writeback data width (matches instruction/data word).
- `ADDR_W`, 10, register address width.
- `PC_W`, 10, program counter width.
- `STAMP_W`, 10, cycle-stamp width.
- `DEPTH`, 64, FIFO depth in records; power of two, ≥ 2.

Ports:
- `clk` in 1: single clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: sample strobe, same pulse the core receives.
- `write_en` in 1: core writeback strobe.
- `addr_w` in ADDR_W: writeback address.
- `data_w` in DATA_W: writeback data.
- `pc_wb` in PC_W: PC of the writing instruction.
- `arm` in 1: pulse; clears the buffer and enters ARMED.
- `disarm` in 1: pulse; returns to IDLE, buffer retained.
- `cont` in 1: 0 = single-shot, 1 = continuous; sampled on `arm`.
- `filt_en` in 1: enable address-window filter; sampled on `arm`.
- `filt_lo`, `filt_hi` in ADDR_W each: inclusive window bounds; sampled on `arm`.
- `rd_valid` out 1: head record available.
- `rd_ready` in 1: host accepts head record.
- `rd_data` out STAMP_W+PC_W+ADDR_W+DATA_W: `{stamp, pc, addr, data}`, MSB first.
- `state` out 2: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
- `count` out clog2(DEPTH+1): records held.
- `overflow` out 1: sticky; a qualifying write was dropped.

## Operation
- **States:**
  - IDLE → ARMED on `arm`.
  - ARMED → CAPTURE on `start`.
  - CAPTURE → DONE when single-shot and either a second `start` arrives or the buffer is full.
  - DONE → ARMED on `arm`.
  - Any state → IDLE on `disarm`. `disarm` wins over a simultaneous `arm`.
  - `arm` in ARMED or CAPTURE re-arms: buffer cleared, state ARMED.
- **`arm` action:** empties the FIFO, clears `overflow`, latches `cont`, `filt_en`, `filt_lo`, `filt_hi`.
- **Stamp counter:** cleared to 0 by every `start`, +1 per cycle, saturates at all-ones. The first cycle after `start` has stamp 0.
- **Qualifying write:** `write_en` in CAPTURE, and (if `filt_en`) `filt_lo ≤ addr_w ≤ filt_hi`, unsigned. If `filt_lo > filt_hi`, nothing qualifies.
- **Push:** a qualifying write pushes `{stamp, pc_wb, addr_w, data_w}`.
- **Full:**
  - Single-shot: FSM is already DONE, so no push occurs.
  - Continuous: the new record is dropped and `overflow` is set. The oldest record is kept.
- **Full with pop:** a push and a pop in the same cycle while full both succeed; no overflow.
- **Frame boundaries:**
  - A write coinciding with `start` in ARMED is not captured.
  - In continuous CAPTURE, a write coinciding with `start` is captured with the pre-reset stamp.
  - In single-shot CAPTURE, the ending `start`'s coincident write is not captured.
- **Readout:** allowed in every state. Pop occurs when `rd_valid && rd_ready`. `rd_data` is stable while `rd_valid && !rd_ready`.

## Timing
- **Reset values:**
  - Outputs: `state`=IDLE, `count`=0, `overflow`=0, `rd_valid`=0, `rd_data`=0.
  - Latched config: 0.
  - Stamp counter: 0.
- **Push latency:** push at edge N makes `rd_valid`=1 after edge N when the FIFO was empty (first-word-fall-through, registered head).
- **`count`:** updates at the same edge as a push or pop. A simultaneous push and pop leaves it unchanged.
- **State transitions:** take effect at the edge that samples the trigger. `state`=CAPTURE is visible in the cycle whose stamp is 0.
- **`reset_n` mid-capture:** immediate return to reset values; FIFO contents lost.

## Structure
- **Package `dsp_trace_pkg`:**
  - State enum `trace_state_t`.
  - Record struct `trace_rec_t`, parametrised by width localparams.
  - Default width constants shared with the core (`DATA_W`=36, `ADDR_W`=10).
- **Sub-module `trace_fifo`:** synchronous FWFT FIFO with registered head.
  - Controls: `push`, `pop`, `clear`.
  - Outputs: `full`, `empty`, `count`.
- **Top level:** FSM, stamp counter, filter, overflow logic.

## Test plan
- **Single-shot, unfiltered:** `arm`; `start`; writes to addr 0x001 at stamps 2, 3, 4 with data 0x400, 0x800, 0xC00; second `start` → `state`=DONE, `count`=3, records pop in order with stamps 2/3/4; a write after DONE is not captured.
- **Filter:** `filt_en`=1, window 0x010–0x01F; writes to 0x00F, 0x010, 0x01F, 0x020 → only 0x010 and 0x01F captured, `count`=2. Inverted window 0x020–0x010 → `count`=0.
- **Continuous overflow:** `cont`=1, `DEPTH`=4; 6 writes with `rd_ready`=0 → `count`=4, `overflow`=1, head is the first write. Full + push + pop same cycle → `count` stays 4, no new overflow.
- **Stamp reset across frames:** `cont`=1; write 5 cycles after `start`, then `start`, then write 1 cycle later → stamps 4, then 0. A write coincident with the second `start` is captured with stamp 5.
- **Backpressure:** hold `rd_ready`=0 with `rd_valid`=1 for 3 cycles → `rd_data` unchanged. A single-cycle `rd_ready` pops exactly one record.
- **Reset/disarm:** `disarm` mid-CAPTURE → IDLE with records retained and readable. `reset_n` low mid-CAPTURE → all outputs at reset values asynchronously. `arm` and `disarm` together → IDLE.
